// File: rtl/data_sram_resp_pkg.sv
// Shared defines for the data-side SRAM responder: opcodes, FSM encodings, latched transaction.
package data_sram_resp_pkg;

  // Request opcodes carried on the wr input.
  localparam logic OpRead  = 1'b0;
  localparam logic OpWrite = 1'b1;

  // Width of the WAIT-state countdown; covers LATENCY up to 15.
  localparam int unsigned LatW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // Request attributes captured at acceptance.
  typedef struct packed {
    logic       wr;
    logic [3:0] wstrb;
  } txn_t;

endpackage

// File: rtl/data_sram_resp_bram_be.sv
// Word array with per-byte-lane synchronous write enables and asynchronous read.
module bram_be #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic [3:0]       be_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [3:0][7:0] mem_q [Depth];

  // Byte-lane writes; lanes with a clear enable keep their contents.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        mem_q[waddr_i][i] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_sram_resp.sv
// CPU data-side SRAM responder: accepts one request at a time in IDLE, completes it
// LATENCY cycles later with a single data_ok pulse.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [LatW-1:0]   cnt_q, cnt_d;
  txn_t              txn_q, txn_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [IdxW-1:0]   acc_idx;
  logic [IdxW-1:0]   rd_idx;
  logic [31:0]       rd_word;
  logic              accept;
  logic [3:0]        wr_be;

  // Byte offset and bits above the array span play no part in addressing.
  logic unused_addr;
  logic unused_wstrb;
  assign unused_addr  = ^{addr[31:IdxW+2], addr[1:0]};
  assign unused_wstrb = ^txn_q.wstrb;

  assign acc_idx = addr[IdxW+1:2];
  assign accept  = req && addr_ok && resetn;
  // Gating with wr keeps X on wstrb from reaching the array during reads.
  assign wr_be   = (accept && (wr == OpWrite)) ? wstrb : 4'b0000;

  bram_be #(
    .Depth(DEPTH_WORDS),
    .AddrW(IdxW)
  ) u_bram_be (
    .clk_i  (clk),
    .be_i   (wr_be),
    .waddr_i(acc_idx),
    .wdata_i(wdata),
    .raddr_i(rd_idx),
    .rdata_o(rd_word)
  );

  // Next-state, countdown, transaction capture and handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    txn_d   = txn_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rd_idx  = idx_q;
    unique case (state_q)
      StIdle: begin
        addr_ok = 1'b1;
        // LATENCY=1 samples the array on the acceptance edge, so read the live index.
        rd_idx  = acc_idx;
        if (req) begin
          txn_d = '{wr: wr, wstrb: wstrb};
          idx_d = acc_idx;
          if (LATENCY <= 1) begin
            state_d = StResp;
            if (wr == OpRead) rdata_d = rd_word;
          end else begin
            state_d = StWait;
            cnt_d   = LatW'(LATENCY - 2);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          if (txn_q.wr == OpRead) rdata_d = rd_word;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        data_ok = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; memory is left untouched.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      txn_q   <= '0;
      idx_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      txn_q   <= txn_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench: three instances (LATENCY 2, 3, 1) driven one at a time,
// read expectations queued at acceptance and checked at data_ok.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_r;
  logic        wr_r;
  logic [3:0]  wstrb_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  int          sel;

  logic [2:0]  req_v;
  logic [2:0]  addr_ok_v;
  logic [2:0]  data_ok_v;
  logic [31:0] rdata_v [3];

  logic [31:0] model [3][1024];
  logic [31:0] sb [$];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign req_v[0] = req_r && (sel == 0);
  assign req_v[1] = req_r && (sel == 1);
  assign req_v[2] = req_r && (sel == 2);

  data_sram_resp #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .resetn(resetn), .req(req_v[0]), .wr(wr_r), .wstrb(wstrb_r),
    .addr(addr_r), .wdata(wdata_r), .addr_ok(addr_ok_v[0]), .data_ok(data_ok_v[0]),
    .rdata(rdata_v[0])
  );

  data_sram_resp #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .resetn(resetn), .req(req_v[1]), .wr(wr_r), .wstrb(wstrb_r),
    .addr(addr_r), .wdata(wdata_r), .addr_ok(addr_ok_v[1]), .data_ok(data_ok_v[1]),
    .rdata(rdata_v[1])
  );

  data_sram_resp #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .resetn(resetn), .req(req_v[2]), .wr(wr_r), .wstrb(wstrb_r),
    .addr(addr_r), .wdata(wdata_r), .addr_ok(addr_ok_v[2]), .data_ok(data_ok_v[2]),
    .rdata(rdata_v[2])
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] s,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One full transaction on instance k; called at posedge+1, returns at posedge+1.
  task automatic txn(input int k, input logic w, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] d, input int lat, input string name);
    int n;
    logic [31:0] exp;
    logic [9:0] idx;
    sel = k; req_r = 1'b1; wr_r = w; wstrb_r = s; addr_r = a; wdata_r = d;
    idx = a[11:2];
    n = 0;
    @(negedge clk);
    while (!addr_ok_v[k] && n < 20) begin @(negedge clk); n++; end
    vecs++;
    if (addr_ok_v[k] !== 1'b1) begin
      $display("FAIL %s accept: addr_ok=%b required 1", name, addr_ok_v[k]); errs++;
    end
    if (w) model[k][idx] = merge(model[k][idx], s, d);
    else   sb.push_back(model[k][idx]);
    @(posedge clk); #1;
    req_r = 1'b0; wstrb_r = 4'bxxxx; wdata_r = 32'hxxxx_xxxx;
    n = 1;
    @(negedge clk);
    while (!data_ok_v[k] && n < 20) begin @(negedge clk); n++; end
    vecs++;
    if (n != lat || data_ok_v[k] !== 1'b1) begin
      $display("FAIL %s latency: data_ok after %0d cycles, required %0d", name, n, lat); errs++;
    end
    if (!w) begin
      exp = sb.pop_front();
      vecs++;
      if (rdata_v[k] !== exp) begin
        $display("FAIL %s rdata: got %h required %h", name, rdata_v[k], exp); errs++;
      end
    end
    @(negedge clk);
    vecs++;
    if (data_ok_v[k] !== 1'b0) begin
      $display("FAIL %s pulse width: data_ok=%b required 0", name, data_ok_v[k]); errs++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_r = 1'b0; wr_r = 1'b0; wstrb_r = 4'h0; addr_r = '0; wdata_r = '0;
    sel = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (addr_ok_v[k] !== 1'b1 || data_ok_v[k] !== 1'b0 || rdata_v[k] !== 32'h0) begin
        $display("FAIL reset[%0d]: addr_ok=%b data_ok=%b rdata=%h required 1 0 00000000",
                 k, addr_ok_v[k], data_ok_v[k], rdata_v[k]);
        errs++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_write();
    txn(0, 1'b1, 4'b1111, 32'h10, 32'h1122_3344, 2, "bw_init");
    txn(0, 1'b1, 4'b0100, 32'h10, 32'hAAAA_AAAA, 2, "bw_lane2");
    txn(0, 1'b0, 4'b0000, 32'h12, 32'h0, 2, "bw_read");
  endtask

  task automatic test_wrap();
    txn(0, 1'b1, 4'b1111, 32'h1000, 32'hDEAD_BEEF, 2, "wrap_wr");
    txn(0, 1'b0, 4'b0000, 32'h0, 32'h0, 2, "wrap_rd");
  endtask

  task automatic test_back_to_back();
    txn(0, 1'b1, 4'b0011, 32'h20, 32'h0000_5566, 2, "raw_wr0");
    txn(0, 1'b1, 4'b1100, 32'h20, 32'h7788_0000, 2, "raw_wr1");
    txn(0, 1'b0, 4'b0000, 32'h20, 32'h0, 2, "raw_rd");
  endtask

  task automatic test_reset_mid();
    sel = 0; req_r = 1'b1; wr_r = 1'b0; wstrb_r = 4'h0; addr_r = 32'h10;
    @(negedge clk);
    vecs++;
    if (addr_ok_v[0] !== 1'b1) begin
      $display("FAIL rmid accept: addr_ok=%b required 1", addr_ok_v[0]); errs++;
    end
    @(posedge clk); #1;
    req_r = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vecs++;
      if (data_ok_v[0] !== 1'b0) begin
        $display("FAIL rmid data_ok cycle %0d: got %b required 0", c, data_ok_v[0]); errs++;
      end
      if (c == 0) begin
        vecs++;
        if (rdata_v[0] !== 32'h0) begin
          $display("FAIL rmid rdata: got %h required 00000000", rdata_v[0]); errs++;
        end
      end
    end
    @(posedge clk); #1;
    txn(0, 1'b0, 4'b0000, 32'h10, 32'h0, 2, "rmid_fresh");
  endtask

  task automatic test_back_pressure();
    sel = 1; req_r = 1'b1; wr_r = 1'b1; wstrb_r = 4'hF;
    for (int c = 0; c < 16; c++) begin
      addr_r  = 32'(c * 4);
      wdata_r = 32'hC0DE_0000 | 32'(c);
      @(negedge clk);
      vecs++;
      if (addr_ok_v[1] !== (c % 4 == 0) || data_ok_v[1] !== (c % 4 == 3)) begin
        $display("FAIL bp cycle %0d: addr_ok=%b data_ok=%b required %b %b", c, addr_ok_v[1],
                 data_ok_v[1], (c % 4 == 0), (c % 4 == 3));
        errs++;
      end
      if (c % 4 == 0) model[1][c] = wdata_r;
      @(posedge clk); #1;
    end
    req_r = 1'b0;
    vecs++;
    if (rdata_v[1] !== 32'h0) begin
      $display("FAIL bp rdata hold: got %h required 00000000", rdata_v[1]); errs++;
    end
    txn(1, 1'b0, 4'b0000, 32'h10, 32'h0, 3, "bp_rd4");
    txn(1, 1'b0, 4'b0000, 32'h30, 32'h0, 3, "bp_rd12");
  endtask

  task automatic test_null_strobe();
    txn(2, 1'b1, 4'b1111, 32'h40, 32'h1234_5678, 1, "ns_init");
    txn(2, 1'b1, 4'b0000, 32'h40, 32'hFFFF_FFFF, 1, "ns_null");
    txn(2, 1'b0, 4'b0000, 32'h40, 32'h0, 1, "ns_read");
    // Read with undriven strobe/data must not disturb the array.
    txn(2, 1'b0, 4'bxxxx, 32'h40, 32'hxxxx_xxxx, 1, "ns_xread");
    txn(2, 1'b0, 4'b0000, 32'h40, 32'h0, 1, "ns_reread");
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_back_pressure();
    test_null_strobe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
